spi_word_master: RTL and testbench

//  SPI initiator (mode 0, MSB first) that serializes 16-bit words onto nCS/SCK/MOSI.

---
 rtl/spi_pkg.sv | 28 ++
 rtl/spi_clk_div.sv | 27 ++
 rtl/spi_word_master.sv | 240 ++++++++++++++++++++++++
 tb/tb_spi_word_master.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared state encoding, word width and default timing for the SPI word master.
package spi_pkg;

  localparam int WORD_W          = 16;
  localparam int DEF_HALF_PERIOD = 2;
  localparam int DEF_CS_SETUP    = 2;
  localparam int DEF_CS_IDLE     = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    LOW   = 3'd2,
    HIGH  = 3'd3,
    STALL = 3'd4,
    TRAIL = 3'd5,
    GAP   = 3'd6
  } spi_state_t;

  // One divider serves every timed phase, so it must hold the longest count.
  function automatic int div_width(input int hp, input int setup, input int idle);
    int m;
    m = hp;
    m = (setup > m) ? setup : m;
    m = (idle > m) ? idle : m;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/spi_clk_div.sv
// Loadable down-counter; phase_done marks the last cycle of an N-cycle phase.
module spi_clk_div #(
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic          phase_done
);

  logic [CW-1:0] cnt_r;

  // Reload on every phase entry, then count down to zero and park there.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {CW{1'b0}};
    end else if (load) begin
      cnt_r <= load_val;
    end else if (cnt_r != {CW{1'b0}}) begin
      cnt_r <= cnt_r - CW'(1);
    end
  end

  assign phase_done = (cnt_r == CW'(1));

endmodule

// File: rtl/spi_word_master.sv
// Mode-0, MSB-first SPI initiator streaming framed 16-bit words to the u4k loader.
// Define SPI_MISO_EN to capture MISO into rx_data/rx_valid; otherwise MISO is ignored.
module spi_word_master
  import spi_pkg::*;
#(
  parameter int WIDTH       = WORD_W,
  parameter int HALF_PERIOD = DEF_HALF_PERIOD,
  parameter int CS_SETUP    = DEF_CS_SETUP,
  parameter int CS_IDLE     = DEF_CS_IDLE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             busy,
  output logic             nCS,
  output logic             SCK,
  output logic             MOSI,
  input  logic             MISO,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid
);

  localparam int BIT_W = $clog2(WIDTH);
  localparam int DIV_W = div_width(HALF_PERIOD, CS_SETUP, CS_IDLE);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WIDTH - 1);
  localparam logic [DIV_W-1:0] HP_V     = DIV_W'(HALF_PERIOD);
  localparam logic [DIV_W-1:0] SETUP_V  = DIV_W'(CS_SETUP);
  localparam logic [DIV_W-1:0] IDLE_V   = DIV_W'(CS_IDLE);

  spi_state_t       state_r;
  spi_state_t       state_nxt_s;

  logic             hold_full_r;
  logic [WIDTH-1:0] hold_data_r;
  logic             hold_last_r;
  logic             in_ready_r;

  logic [WIDTH-1:0] sh_r;
  logic             word_last_r;
  logic [BIT_W-1:0] bit_cnt_r;
  logic             last_bit_s;

  logic             ncs_r;
  logic             sck_r;
  logic             busy_r;
  logic             ncs_nxt_s;
  logic             sck_nxt_s;
  logic             busy_nxt_s;

  logic             ld_word_s;
  logic             shift_s;
  logic             word_end_s;
  logic             div_load_s;
  logic [DIV_W-1:0] div_val_s;
  logic             phase_done_s;

  assign last_bit_s = (bit_cnt_r == LAST_BIT);

  spi_clk_div #(
    .CW(DIV_W)
  ) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (div_load_s),
    .load_val  (div_val_s),
    .phase_done(phase_done_s)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (hold_full_r) state_nxt_s = SETUP;
        else             state_nxt_s = IDLE;
      end
      SETUP: begin
        if (phase_done_s) state_nxt_s = HIGH;
        else              state_nxt_s = SETUP;
      end
      HIGH: begin
        if (!phase_done_s)    state_nxt_s = HIGH;
        else if (!last_bit_s) state_nxt_s = LOW;
        else if (word_last_r) state_nxt_s = TRAIL;
        else if (hold_full_r) state_nxt_s = LOW;
        else                  state_nxt_s = STALL;
      end
      LOW: begin
        if (phase_done_s) state_nxt_s = HIGH;
        else              state_nxt_s = LOW;
      end
      STALL: begin
        if (hold_full_r) state_nxt_s = LOW;
        else             state_nxt_s = STALL;
      end
      TRAIL: begin
        if (phase_done_s) state_nxt_s = GAP;
        else              state_nxt_s = TRAIL;
      end
      GAP: begin
        // A waiting word opens the next frame directly, so nCS stays high exactly CS_IDLE cycles.
        if (!phase_done_s)    state_nxt_s = GAP;
        else if (hold_full_r) state_nxt_s = SETUP;
        else                  state_nxt_s = IDLE;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Datapath strobes, divider reload and next values of the registered pins.
  always_comb begin
    ld_word_s  = 1'b0;
    shift_s    = 1'b0;
    word_end_s = 1'b0;
    case (state_r)
      IDLE:  ld_word_s = hold_full_r;
      HIGH: begin
        shift_s    = phase_done_s && !last_bit_s;
        word_end_s = phase_done_s && last_bit_s;
        ld_word_s  = word_end_s && !word_last_r && hold_full_r;
      end
      STALL: ld_word_s = hold_full_r;
      GAP:   ld_word_s = phase_done_s && hold_full_r;
      default: begin
        ld_word_s  = 1'b0;
        shift_s    = 1'b0;
        word_end_s = 1'b0;
      end
    endcase

    div_load_s = (state_nxt_s != state_r);
    case (state_nxt_s)
      SETUP:           div_val_s = SETUP_V;
      LOW, HIGH, TRAIL: div_val_s = HP_V;
      GAP:             div_val_s = IDLE_V;
      default:         div_val_s = {DIV_W{1'b0}};
    endcase

    ncs_nxt_s  = (state_nxt_s == IDLE) || (state_nxt_s == GAP);
    sck_nxt_s  = (state_nxt_s == HIGH);
    busy_nxt_s = (state_nxt_s != IDLE);
  end

  // Pin registers follow the next state so they line up with state_r.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ncs_r  <= 1'b1;
      sck_r  <= 1'b0;
      busy_r <= 1'b0;
    end else begin
      ncs_r  <= ncs_nxt_s;
      sck_r  <= sck_nxt_s;
      busy_r <= busy_nxt_s;
    end
  end

  // Single-entry holding register; in_ready is low whenever it is full, so no bypass.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_full_r <= 1'b0;
      hold_data_r <= {WIDTH{1'b0}};
      hold_last_r <= 1'b0;
      in_ready_r  <= 1'b1;
    end else if (ld_word_s) begin
      hold_full_r <= 1'b0;
      in_ready_r  <= 1'b1;
    end else if (in_valid && in_ready_r) begin
      hold_full_r <= 1'b1;
      hold_data_r <= in_data;
      hold_last_r <= in_last;
      in_ready_r  <= 1'b0;
    end
  end

  // Output shifter; its MSB is MOSI, so MOSI only moves on load or at a falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_r        <= {WIDTH{1'b0}};
      word_last_r <= 1'b0;
      bit_cnt_r   <= {BIT_W{1'b0}};
    end else if (ld_word_s) begin
      sh_r        <= hold_data_r;
      word_last_r <= hold_last_r;
      bit_cnt_r   <= {BIT_W{1'b0}};
    end else if (shift_s) begin
      sh_r      <= {sh_r[WIDTH-2:0], 1'b0};
      bit_cnt_r <= bit_cnt_r + BIT_W'(1);
    end
  end

  assign in_ready = in_ready_r;
  assign busy     = busy_r;
  assign nCS      = ncs_r;
  assign SCK      = sck_r;
  assign MOSI     = sh_r[WIDTH-1];

`ifdef SPI_MISO_EN
  logic [WIDTH-1:0] rx_sh_r;
  logic [WIDTH-1:0] rx_data_r;
  logic             rx_valid_r;
  logic             sck_rise_s;

  assign sck_rise_s = (state_nxt_s == HIGH) && (state_r != HIGH);

  // Sample MISO at each rising SCK edge; publish the word as its last high phase ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_sh_r    <= {WIDTH{1'b0}};
      rx_data_r  <= {WIDTH{1'b0}};
      rx_valid_r <= 1'b0;
    end else begin
      rx_valid_r <= word_end_s;
      if (sck_rise_s) rx_sh_r <= {rx_sh_r[WIDTH-2:0], MISO};
      if (word_end_s) rx_data_r <= rx_sh_r;
    end
  end

  assign rx_data  = rx_data_r;
  assign rx_valid = rx_valid_r;
`else
  logic miso_unused_s;

  assign miso_unused_s = MISO;
  assign rx_data       = {WIDTH{1'b0}};
  assign rx_valid      = 1'b0;
`endif

endmodule

// File: tb/tb_spi_word_master.sv
// Self-checking bench for spi_word_master: a bit-level slave model rebuilds words
// from SCK/MOSI and compares them and the frame timing against the pushed stream.
module tb_spi_word_master;

  localparam int HP  = 2;
  localparam int CSI = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] in_data;
  logic        in_last, in_valid;
  logic        in_ready, busy, ncs, sck, mosi, rx_valid;
  logic [15:0] rx_data;

  logic [15:0] f_data;
  logic        f_last, f_valid;
  logic        f_ready, f_busy, f_ncs, f_sck, f_mosi, f_rx_valid;
  logic [15:0] f_rx_data;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  spi_word_master dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_last(in_last), .in_valid(in_valid),
    .in_ready(in_ready), .busy(busy), .nCS(ncs), .SCK(sck), .MOSI(mosi), .MISO(mosi),
    .rx_data(rx_data), .rx_valid(rx_valid)
  );

  spi_word_master #(.HALF_PERIOD(1), .CS_IDLE(1)) dut_f (
    .clk(clk), .rst_n(rst_n), .in_data(f_data), .in_last(f_last), .in_valid(f_valid),
    .in_ready(f_ready), .busy(f_busy), .nCS(f_ncs), .SCK(f_sck), .MOSI(f_mosi), .MISO(f_mosi),
    .rx_data(f_rx_data), .rx_valid(f_rx_valid)
  );

  // Slave model state for the main instance.
  logic [15:0] exp_q[$];
  logic [15:0] rxq[$];
  logic [15:0] sh_m = 16'h0000;
  int nbits_m = 0, rises_m = 0, frames_m = 0, mosi_bad = 0, sck_bad = 0;
  int last_rise = 0, min_gap_m = 1000, max_gap_m = 0, rx_pulses = 0;
  bit have_rise = 1'b0;
  logic [15:0] rx_last = 16'h0000;
  logic prev_sck = 1'b0, prev_mosi = 1'b0, prev_ncs = 1'b1;

  always @(negedge clk) begin
    if (rst_n !== 1'b1) begin
      nbits_m = 0;
    end else begin
      if (!ncs && prev_ncs) begin
        frames_m++; nbits_m = 0; have_rise = 1'b0; min_gap_m = 1000; max_gap_m = 0;
      end
      if (sck && !prev_sck) begin
        rises_m++;
        if (mosi !== prev_mosi) mosi_bad++;
        if (have_rise) begin
          if (cyc - last_rise < min_gap_m) min_gap_m = cyc - last_rise;
          if (cyc - last_rise > max_gap_m) max_gap_m = cyc - last_rise;
        end
        have_rise = 1'b1; last_rise = cyc;
        sh_m = {sh_m[14:0], mosi}; nbits_m++;
        if (nbits_m == 16) begin rxq.push_back(sh_m); nbits_m = 0; end
      end else if (sck && prev_sck && mosi !== prev_mosi) begin
        mosi_bad++;
      end
      if (ncs && sck) sck_bad++;
      if (rx_valid) begin rx_pulses++; rx_last = rx_data; end
    end
    prev_sck = sck; prev_mosi = mosi; prev_ncs = ncs;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] d, input logic l);
    int n = 0;
    in_valid = 1'b1; in_data = d; in_last = l;
    while (in_ready !== 1'b1 && n < 3000) begin step(); n++; end
    checks++;
    if (n >= 3000) begin fails++; $display("FAIL push_timeout: in_ready=%b required 1", in_ready); end
    step();
    exp_q.push_back(d);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(busy === 1'b0 && in_ready === 1'b1) && n < 3000) begin step(); n++; end
    checks++;
    if (n >= 3000) begin fails++; $display("FAIL idle_timeout: busy=%b required 0", busy); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_data = 16'h0000; in_last = 1'b0;
    f_valid = 1'b0; f_data = 16'h0000; f_last = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    repeat (2) step();
    checks += 9;
    if (ncs !== 1'b1)          begin fails++; $display("FAIL rst_ncs: got %b want 1", ncs); end
    if (sck !== 1'b0)          begin fails++; $display("FAIL rst_sck: got %b want 0", sck); end
    if (mosi !== 1'b0)         begin fails++; $display("FAIL rst_mosi: got %b want 0", mosi); end
    if (in_ready !== 1'b1)     begin fails++; $display("FAIL rst_ready: got %b want 1", in_ready); end
    if (busy !== 1'b0)         begin fails++; $display("FAIL rst_busy: got %b want 0", busy); end
    if (rx_valid !== 1'b0)     begin fails++; $display("FAIL rst_rxv: got %b want 0", rx_valid); end
    if (rx_data !== 16'h0000)  begin fails++; $display("FAIL rst_rxd: got %h want 0000", rx_data); end
    if (f_ncs !== 1'b1)        begin fails++; $display("FAIL rst_f_ncs: got %b want 1", f_ncs); end
    if (f_sck !== 1'b0)        begin fails++; $display("FAIL rst_f_sck: got %b want 0", f_sck); end
  endtask

  task automatic test_single();
    int r0 = rises_m, fr0 = frames_m, t_fall = -1, t_ncs = -1, t_busy = -1;
    logic ps, pn, pb;
    logic [15:0] e, g;
    push(16'h8003, 1'b1);
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin fails++; $display("FAIL single_hold_full: in_ready=%b want 0", in_ready); end
    step();
    checks += 2;
    if (ncs !== 1'b0)  begin fails++; $display("FAIL single_ncs_fall: got %b want 0", ncs); end
    if (busy !== 1'b1) begin fails++; $display("FAIL single_busy: got %b want 1", busy); end
    ps = sck; pn = ncs; pb = busy;
    for (int i = 0; i < 300; i++) begin
      step();
      if (!sck && ps) t_fall = cyc;
      if (ncs && !pn) t_ncs = cyc;
      if (!busy && pb) begin t_busy = cyc; break; end
      ps = sck; pn = ncs; pb = busy;
    end
    checks += 4;
    if (rises_m - r0 != 16)   begin fails++; $display("FAIL single_rises: got %0d want 16", rises_m - r0); end
    if (frames_m - fr0 != 1)  begin fails++; $display("FAIL single_frames: got %0d want 1", frames_m - fr0); end
    if (t_ncs - t_fall != HP) begin fails++; $display("FAIL single_trail: got %0d want %0d", t_ncs - t_fall, HP); end
    if (t_busy - t_ncs != CSI) begin fails++; $display("FAIL single_gap: got %0d want %0d", t_busy - t_ncs, CSI); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = (rxq.size() > 0) ? rxq.pop_front() : 16'hxxxx;
      checks++;
      if (g !== e) begin fails++; $display("FAIL single_word: got %h want %h", g, e); end
    end
  endtask

  task automatic test_burst();
    logic [15:0] w[18];
    logic [15:0] e, g;
    int r0 = rises_m, fr0 = frames_m;
    w[0] = 16'h8003; w[1] = 16'h8101; w[2] = 16'h0dc0; w[17] = 16'h4004;
    for (int i = 3; i < 17; i++) w[i] = 16'($urandom);
    for (int i = 0; i < 18; i++) push(w[i], (i == 17) ? 1'b1 : 1'b0);
    in_valid = 1'b0;
    wait_idle();
    checks += 6;
    if (rises_m - r0 != 288)  begin fails++; $display("FAIL burst_rises: got %0d want 288", rises_m - r0); end
    if (frames_m - fr0 != 1)  begin fails++; $display("FAIL burst_frames: got %0d want 1", frames_m - fr0); end
    if (max_gap_m != 2 * HP)  begin fails++; $display("FAIL burst_max_gap: got %0d want %0d", max_gap_m, 2 * HP); end
    if (min_gap_m != 2 * HP)  begin fails++; $display("FAIL burst_min_gap: got %0d want %0d", min_gap_m, 2 * HP); end
    if (mosi_bad != 0)        begin fails++; $display("FAIL mosi_stable: got %0d changes want 0", mosi_bad); end
    if (sck_bad != 0)         begin fails++; $display("FAIL sck_idle: got %0d want 0", sck_bad); end
    for (int i = 0; i < 18; i++) begin
      e = exp_q.pop_front(); g = (rxq.size() > 0) ? rxq.pop_front() : 16'hxxxx;
      checks++;
      if (g !== e) begin fails++; $display("FAIL burst_word%0d: got %h want %h", i, g, e); end
    end
  endtask

  task automatic test_stall();
    int r0 = rises_m, fr0 = frames_m, ncs_hi = 0, sck_late = 0;
    logic [15:0] e, g;
    push(16'($urandom), 1'b0);
    in_valid = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (ncs) ncs_hi++;
      if (i >= 70 && sck) sck_late++;
    end
    checks += 4;
    if (rises_m - r0 != 16) begin fails++; $display("FAIL stall_rises: got %0d want 16", rises_m - r0); end
    if (ncs_hi != 0)        begin fails++; $display("FAIL stall_ncs: high %0d cycles want 0", ncs_hi); end
    if (sck_late != 0)      begin fails++; $display("FAIL stall_sck: high %0d cycles want 0", sck_late); end
    if (busy !== 1'b1)      begin fails++; $display("FAIL stall_busy: got %b want 1", busy); end
    push(16'($urandom), 1'b1);
    in_valid = 1'b0;
    wait_idle();
    checks += 2;
    if (frames_m - fr0 != 1) begin fails++; $display("FAIL stall_frames: got %0d want 1", frames_m - fr0); end
    if (rises_m - r0 != 32)  begin fails++; $display("FAIL stall_rises2: got %0d want 32", rises_m - r0); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = (rxq.size() > 0) ? rxq.pop_front() : 16'hxxxx;
      checks++;
      if (g !== e) begin fails++; $display("FAIL stall_word: got %h want %h", g, e); end
    end
  endtask

  task automatic test_reset_mid();
    int r0 = rises_m, n = 0;
    logic [15:0] e, g;
    push(16'hFFFF, 1'b1);
    in_valid = 1'b0;
    while (rises_m - r0 < 7 && n < 500) begin step(); n++; end
    rst_n = 1'b0;
    #1;
    checks += 5;
    if (ncs !== 1'b1)      begin fails++; $display("FAIL abort_ncs: got %b want 1", ncs); end
    if (sck !== 1'b0)      begin fails++; $display("FAIL abort_sck: got %b want 0", sck); end
    if (mosi !== 1'b0)     begin fails++; $display("FAIL abort_mosi: got %b want 0", mosi); end
    if (busy !== 1'b0)     begin fails++; $display("FAIL abort_busy: got %b want 0", busy); end
    if (in_ready !== 1'b1) begin fails++; $display("FAIL abort_ready: got %b want 1", in_ready); end
    void'(exp_q.pop_back());
    repeat (2) step();
    rst_n = 1'b1;
    step();
    r0 = rises_m;
    push(16'h0840, 1'b1);
    in_valid = 1'b0;
    wait_idle();
    checks++;
    if (rises_m - r0 != 16) begin fails++; $display("FAIL abort_rises: got %0d want 16", rises_m - r0); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = (rxq.size() > 0) ? rxq.pop_front() : 16'hxxxx;
      checks++;
      if (g !== e) begin fails++; $display("FAIL abort_word: got %h want %h", g, e); end
    end
  endtask

  task automatic test_fast();
    logic [15:0] wa, wb, sh;
    logic [15:0] fq[$];
    int frames_f = 0, hi_run = 0, nb = 0, lr = 0, mn = 1000, mx = 0, k = 0;
    bit hr = 1'b0, done = 1'b0;
    logic ps, pn;
    wa = 16'($urandom); wb = 16'($urandom); sh = 16'h0000;
    ps = f_sck; pn = f_ncs;
    fork
      begin
        f_valid = 1'b1; f_data = wa; f_last = 1'b1;
        while (f_ready !== 1'b1 && k < 200) begin step(); k++; end
        step();
        f_data = wb;
        while (f_ready !== 1'b1 && k < 200) begin step(); k++; end
        step();
        f_valid = 1'b0;
      end
      begin
        for (int n = 0; n < 300 && !done; n++) begin
          step();
          if (!f_ncs && pn) begin frames_f++; hr = 1'b0; end
          if (f_sck && !ps) begin
            if (hr) begin
              if (cyc - lr < mn) mn = cyc - lr;
              if (cyc - lr > mx) mx = cyc - lr;
            end
            hr = 1'b1; lr = cyc;
            sh = {sh[14:0], f_mosi}; nb++;
            if (nb == 16) begin fq.push_back(sh); nb = 0; end
          end
          if (f_ncs && frames_f == 1) hi_run++;
          if (!f_busy && f_ncs && frames_f == 2) done = 1'b1;
          ps = f_sck; pn = f_ncs;
        end
      end
    join
    checks += 6;
    if (!done)         begin fails++; $display("FAIL fast_timeout: frames %0d want 2", frames_f); end
    if (frames_f != 2) begin fails++; $display("FAIL fast_frames: got %0d want 2", frames_f); end
    if (mn != 2 || mx != 2) begin fails++; $display("FAIL fast_period: min %0d max %0d want 2", mn, mx); end
    if (hi_run != 1)   begin fails++; $display("FAIL fast_gap: nCS high %0d want 1", hi_run); end
    if (fq.size() != 2 || fq[0] !== wa) begin fails++; $display("FAIL fast_word0: want %h", wa); end
    if (fq.size() != 2 || fq[1] !== wb) begin fails++; $display("FAIL fast_word1: want %h", wb); end
  endtask

  task automatic test_rx();
    int p0 = rx_pulses;
    logic [15:0] e, g;
`ifdef SPI_MISO_EN
    push(16'hA5C3, 1'b1);
    in_valid = 1'b0;
    wait_idle();
    checks += 2;
    if (rx_pulses - p0 != 1)  begin fails++; $display("FAIL rx_pulses: got %0d want 1", rx_pulses - p0); end
    if (rx_last !== 16'hA5C3) begin fails++; $display("FAIL rx_data: got %h want a5c3", rx_last); end
`else
    push(16'hA5C3, 1'b1);
    in_valid = 1'b0;
    wait_idle();
    checks += 2;
    if (rx_pulses != 0)       begin fails++; $display("FAIL rx_quiet: got %0d pulses want 0", rx_pulses + p0 - p0); end
    if (rx_data !== 16'h0000) begin fails++; $display("FAIL rx_zero: got %h want 0000", rx_data); end
`endif
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = (rxq.size() > 0) ? rxq.pop_front() : 16'hxxxx;
      checks++;
      if (g !== e) begin fails++; $display("FAIL rx_word: got %h want %h", g, e); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_stall();
    test_reset_mid();
    test_fast();
    test_rx();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
